bitcoin_hash_seq: RTL

- Parametrised, single-core successor to the 16-worker Bitcoin nonce search.
- Reads the 19-word header prefix from memory once and computes the block-1 midstate once.
- Then sweeps NUM_NONCES nonces starting at a run-time base, time-multiplexing one SHA-256 round engine over all compressions.
- Either dumps every final H0 (mode 0), or writes only {nonce, H0} pairs whose H0 is below a run-time difficulty target (mode 1).

---
 rtl/bitcoin_hash_seq.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/bitcoin_hash_seq.sv
// Sequential SHA-256d nonce search: one round engine time-multiplexed over the
// header block, then the nonce block and outer hash for every nonce in the sweep.
module bitcoin_hash_seq #(
    parameter int NUM_NONCES = 16,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] message_addr,
    input  logic [ADDR_W-1:0] output_addr,
    input  logic [31:0]       nonce_base,
    input  logic [31:0]       target,
    input  logic              mode,
    output logic              done,
    output logic [15:0]       found_count,
    output logic              mem_clk,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);
    typedef enum logic [2:0] {IDLE, READ, LOAD, ROUND, FINAL, WRITE, DONE} state_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction
    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction
    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t      r_state, w_next;
    logic [6:0]  r_cnt;      // READ cycle, round index, or WRITE beat
    logic [1:0]  r_blk;      // 0 = header block, 1 = nonce block, 2 = outer hash
    logic [15:0] r_k;
    logic [15:0] r_found;
    logic        r_done;
    logic [31:0] r_base, r_target;
    logic        r_mode;
    logic [31:0] r_msg  [0:18];
    logic [31:0] r_mid  [0:7];
    logic [31:0] r_hout [0:7];
    logic [31:0] r_v    [0:7];
    logic [31:0] r_w    [0:15];

    logic [31:0] w_chain [0:7];
    logic [31:0] w_sum   [0:7];
    logic [31:0] w_t1, w_t2, w_wnew, w_nonce;
    logic [4:0]  w_ridx;
    logic        w_last, w_fin_match;

    always_comb begin
        w_t1   = r_v[7] + bsig1(r_v[4]) + ((r_v[4] & r_v[5]) ^ (~r_v[4] & r_v[6])) + K[r_cnt[5:0]] + r_w[0];
        w_t2   = bsig0(r_v[0]) + ((r_v[0] & r_v[1]) ^ (r_v[0] & r_v[2]) ^ (r_v[1] & r_v[2]));
        w_wnew = ssig1(r_w[14]) + r_w[9] + ssig0(r_w[1]) + r_w[0];
        for (int i = 0; i < 8; i++) begin
            w_chain[i] = (r_blk == 2'd1) ? r_mid[i] : IV[i];
            w_sum[i]   = w_chain[i] + r_v[i];
        end
        w_nonce     = r_base + 32'(r_k);
        w_ridx      = 5'(r_cnt - 7'd1);
        w_last      = (r_k == 16'(NUM_NONCES - 1));
        w_fin_match = !r_mode || (w_sum[0] < r_target);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:  if (start) w_next = READ;
            READ:  if (r_cnt == 7'd19) w_next = LOAD;
            LOAD:  w_next = ROUND;
            ROUND: if (r_cnt == 7'd63) w_next = FINAL;
            FINAL: begin
                if (r_blk != 2'd2)    w_next = LOAD;
                else if (w_fin_match) w_next = WRITE;
                else                  w_next = w_last ? DONE : LOAD;
            end
            WRITE: if (!r_mode || r_cnt[0]) w_next = w_last ? DONE : LOAD;
            DONE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        unique case (r_state)
            READ: if (r_cnt < 7'd19) mem_addr = message_addr + ADDR_W'(r_cnt);
            WRITE: begin
                mem_we = 1'b1;
                if (!r_mode) begin
                    mem_addr       = output_addr + ADDR_W'(r_k);
                    mem_write_data = r_hout[0];
                end else begin
                    mem_addr       = output_addr + ADDR_W'({r_found, 1'b0}) + ADDR_W'(r_cnt[0]);
                    mem_write_data = r_cnt[0] ? r_hout[0] : w_nonce;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_blk   <= '0;
            r_k     <= '0;
            r_found <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == DONE);
            unique case (r_state)
                IDLE: if (start) begin
                    r_cnt   <= '0;
                    r_blk   <= '0;
                    r_k     <= '0;
                    r_found <= '0;
                end
                READ:  r_cnt <= (r_cnt == 7'd19) ? 7'd0 : r_cnt + 7'd1;
                LOAD:  r_cnt <= '0;
                ROUND: r_cnt <= r_cnt + 7'd1;
                FINAL: begin
                    r_cnt <= '0;
                    if (r_blk == 2'd2) begin
                        r_blk <= 2'd1;
                        if (w_next == LOAD) r_k <= r_k + 16'd1;
                    end else begin
                        r_blk <= r_blk + 2'd1;
                    end
                end
                WRITE: begin
                    r_cnt <= r_cnt + 7'd1;
                    if (!r_mode || r_cnt[0]) begin
                        r_found <= r_found + 16'd1;
                        if (!w_last) r_k <= r_k + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath: header capture, message schedule window and working variables
    always_ff @(posedge clk) begin
        unique case (r_state)
            IDLE: if (start) begin
                r_base   <= nonce_base;
                r_target <= target;
                r_mode   <= mode;
            end
            READ: if (r_cnt != 7'd0) r_msg[w_ridx] <= mem_read_data;
            LOAD: begin
                for (int i = 0; i < 8; i++) r_v[i] <= w_chain[i];
                for (int j = 0; j < 16; j++) r_w[j] <= 32'h0;
                if (r_blk == 2'd0) begin
                    for (int j = 0; j < 16; j++) r_w[j] <= r_msg[j];
                end else if (r_blk == 2'd1) begin
                    r_w[0]  <= r_msg[16];
                    r_w[1]  <= r_msg[17];
                    r_w[2]  <= r_msg[18];
                    r_w[3]  <= w_nonce;
                    r_w[4]  <= 32'h80000000;
                    r_w[15] <= 32'h00000280;
                end else begin
                    for (int j = 0; j < 8; j++) r_w[j] <= r_hout[j];
                    r_w[8]  <= 32'h80000000;
                    r_w[15] <= 32'h00000100;
                end
            end
            ROUND: begin
                r_v[0] <= w_t1 + w_t2;
                r_v[1] <= r_v[0];
                r_v[2] <= r_v[1];
                r_v[3] <= r_v[2];
                r_v[4] <= r_v[3] + w_t1;
                r_v[5] <= r_v[4];
                r_v[6] <= r_v[5];
                r_v[7] <= r_v[6];
                for (int j = 0; j < 15; j++) r_w[j] <= r_w[j+1];
                r_w[15] <= w_wnew;
            end
            FINAL: begin
                for (int i = 0; i < 8; i++) begin
                    r_hout[i] <= w_sum[i];
                    if (r_blk == 2'd0) r_mid[i] <= w_sum[i];
                end
            end
            default: ;
        endcase
    end

    assign done        = r_done;
    assign found_count = r_found;
    assign mem_clk     = clk;
endmodule
